// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
//
// Two-entry registered result buffer between the ALU operation modules and the
// writeback stage. Results are captured with their opcode tag on a valid/ready
// handshake and presented to writeback in strict FIFO order. in_ready depends
// only on registered state, so writeback stalls never reach back into the ALU
// combinationally.
//
// Optional feature macro: ALU_RESULT_FLAGS_EN
//   When defined, zero/negative flags are derived from in_data at push time,
//   stored with the entry, and driven on out_zero/out_neg.
//
// Parameters:
//   size  datapath width in bits (matches ALU size)
//   opw   opcode tag width in bits
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   ALU result available
//   in_ready   buffer can accept (fewer than 2 entries held)
//   in_data    ALU result
//   in_op      opcode tag travelling with the result
//   out_valid  head entry valid
//   out_ready  writeback consumes the head entry
//   out_data   head result
//   out_op     head opcode tag
//   out_zero   head result == 0           (ALU_RESULT_FLAGS_EN only)
//   out_neg    head result MSB            (ALU_RESULT_FLAGS_EN only)
//   count      entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int size = 8,
  parameter int opw  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] in_data,
  input  logic [opw-1:0]  in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] out_data,
  output logic [opw-1:0]  out_op,
`ifdef ALU_RESULT_FLAGS_EN
  output logic            out_zero,
  output logic            out_neg,
`endif
  output logic [1:0]      count
);

  typedef struct packed {
    logic [size-1:0] data;
    logic [opw-1:0]  op;
`ifdef ALU_RESULT_FLAGS_EN
    logic            zero;
    logic            neg;
`endif
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;

  logic   push;
  logic   pop;
  entry_t new_entry;

  // Handshake qualifiers come only from registered count, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    new_entry      = '0;
    new_entry.data = in_data;
    new_entry.op   = in_op;
`ifdef ALU_RESULT_FLAGS_EN
    // Flags are frozen at capture time and never recomputed at the output.
    new_entry.zero = ~|in_data;
    new_entry.neg  = in_data[size-1];
`endif

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end

    // Popped entries are left in place; only out_valid qualifies the data.
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      // NOTE: storage is small and its reset value is observable on the
      // outputs, so it is reset along with the control state.
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
`ifdef ALU_RESULT_FLAGS_EN
        // Cleared data is zero, so the stored zero flag is kept consistent.
        mem_q[i].zero <= 1'b1;
`endif
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_data = mem_q[rd_ptr_q].data;
  assign out_op   = mem_q[rd_ptr_q].op;
`ifdef ALU_RESULT_FLAGS_EN
  assign out_zero = mem_q[rd_ptr_q].zero;
  assign out_neg  = mem_q[rd_ptr_q].neg;
`endif
  assign count    = count_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
//
// Self-checking bench for alu_result_buffer. Every accepted push places the
// driven data/op into a scoreboard queue; every observed pop is compared with
// the queue head. Flag checks are compiled in when ALU_RESULT_FLAGS_EN is set.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_op;
`ifdef ALU_RESULT_FLAGS_EN
  logic       out_zero;
  logic       out_neg;
`endif
  logic [1:0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] o;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  alu_result_buffer #(.size(8), .opw(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
`ifdef ALU_RESULT_FLAGS_EN
    .out_zero  (out_zero),
    .out_neg   (out_neg),
`endif
    .count     (count)
  );

  // One clock cycle. Called at a falling edge with inputs already driven;
  // records the handshakes that will fire at the next rising edge and returns
  // at the following falling edge.
  task automatic cycle(output bit popped, output logic [7:0] pd, output logic [3:0] po);
    #1;
    popped = out_valid && out_ready;
    pd     = out_data;
    po     = out_op;
    if (in_valid && in_ready && !rst) sb.push_back('{in_data, in_op});
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit popped; logic [7:0] pd; logic [3:0] po;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00; in_op = 4'h0;
    cycle(popped, pd, po);
    rst = 1'b0;
    sb.delete();
    #1;
    checks++; if (count !== 2'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (out_op !== 4'h0)    begin failures++; $display("FAIL reset_out_op got=%h exp=0", out_op); end
`ifdef ALU_RESULT_FLAGS_EN
    checks++; if (out_zero !== 1'b1)  begin failures++; $display("FAIL reset_out_zero got=%b exp=1", out_zero); end
    checks++; if (out_neg !== 1'b0)   begin failures++; $display("FAIL reset_out_neg got=%b exp=0", out_neg); end
`endif
    @(negedge clk);
  endtask

  task automatic test_pass_through();
    bit popped; logic [7:0] pd; logic [3:0] po; exp_t e;
    in_valid = 1'b1; in_data = 8'h5A; in_op = 4'h3; out_ready = 1'b1;
    cycle(popped, pd, po);
    checks++; if (popped) begin failures++; $display("FAIL pass_no_bypass got=pop exp=no_pop"); end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pass_out_valid got=%b exp=1", out_valid); end
    cycle(popped, pd, po);
    checks++;
    if (!popped || sb.size() == 0) begin
      failures++; $display("FAIL pass_pop got=popped:%0b exp=popped:1", popped);
    end else begin
      e = sb.pop_front();
      if (pd !== e.d || po !== e.o || pd !== 8'h5A || po !== 4'h3) begin
        failures++; $display("FAIL pass_data got=%h/%h exp=%h/%h", pd, po, e.d, e.o);
      end
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pass_empty_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill_stall();
    bit popped; logic [7:0] pd; logic [3:0] po; exp_t e;
    logic [7:0] order [3];
    int n;
    order[0] = 8'h11; order[1] = 8'h22; order[2] = 8'h33;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h11; in_op = 4'h1; cycle(popped, pd, po);
    in_data = 8'h22; in_op = 4'h2; cycle(popped, pd, po);
    #1;
    checks++; if (count !== 2'd2)    begin failures++; $display("FAIL fill_count got=%0d exp=2", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    in_data = 8'h33; in_op = 4'h4;
    cycle(popped, pd, po);
    cycle(popped, pd, po);
    #1;
    checks++; if (count !== 2'd2 || out_data !== 8'h11) begin
      failures++; $display("FAIL stall_hold got=count:%0d head:%h exp=count:2 head:11", count, out_data);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8 && n < 3; c++) begin
      cycle(popped, pd, po);
      if (c == 0) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_rise got=%b exp=1", in_ready); end
      end
      if (in_valid && sb.size() > 0 && sb[sb.size()-1].d == 8'h33) in_valid = 1'b0;
      if (popped) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL stall_order got=%h exp=empty_scoreboard", pd);
        end else begin
          e = sb.pop_front();
          if (pd !== e.d || po !== e.o || pd !== order[n]) begin
            failures++; $display("FAIL stall_order got=%h/%h exp=%h/%h", pd, po, order[n], e.o);
          end
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n != 3) begin failures++; $display("FAIL stall_drain got=%0d exp=3", n); end
  endtask

  task automatic test_simultaneous();
    bit popped; logic [7:0] pd; logic [3:0] po; exp_t e;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40; in_op = 4'h5;
    cycle(popped, pd, po);
    out_ready = 1'b1; in_data = 8'h44; in_op = 4'h6;
    cycle(popped, pd, po);
    in_valid = 1'b0;
    if (popped && sb.size() > 0) e = sb.pop_front();
    checks++; if (!popped || pd !== 8'h40) begin failures++; $display("FAIL simul_pop got=%h exp=40", pd); end
    #1;
    checks++; if (count !== 2'd1)     begin failures++; $display("FAIL simul_count got=%0d exp=1", count); end
    checks++; if (out_data !== 8'h44) begin failures++; $display("FAIL simul_head got=%h exp=44", out_data); end
    cycle(popped, pd, po);
    if (popped && sb.size() > 0) e = sb.pop_front();
    checks++; if (!popped || pd !== 8'h44 || po !== 4'h6) begin
      failures++; $display("FAIL simul_second got=%h/%h exp=44/6", pd, po);
    end
  endtask

  task automatic test_wrap();
    bit popped; logic [7:0] pd; logic [3:0] po; exp_t e;
    int n = 0;
    int bad = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 10);
      in_data  = 8'(c);
      in_op    = 4'(c);
      cycle(popped, pd, po);
      if (popped) begin
        if (sb.size() == 0 || pd !== 8'(n)) bad++;
        else begin
          e = sb.pop_front();
          if (pd !== e.d || po !== e.o) bad++;
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n != 10)  begin failures++; $display("FAIL wrap_count got=%0d exp=10", n); end
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_data got=%0d_bad exp=0_bad", bad); end
    checks++; if (count !== 2'd0 || sb.size() != 0) begin
      failures++; $display("FAIL wrap_empty got=count:%0d sb:%0d exp=0/0", count, sb.size());
    end
  endtask

`ifdef ALU_RESULT_FLAGS_EN
  task automatic test_flags();
    bit popped; logic [7:0] pd; logic [3:0] po;
    logic [7:0] vals [3];
    vals[0] = 8'h00; vals[1] = 8'h80; vals[2] = 8'h7F;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i]; in_op = 4'h7;
      cycle(popped, pd, po);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_zero !== ~|vals[i] || out_neg !== vals[i][7]) begin
        failures++;
        $display("FAIL flags_%0d got=%b%b exp=%b%b", i, out_zero, out_neg, ~|vals[i], vals[i][7]);
      end
    end
    in_valid = 1'b0;
    cycle(popped, pd, po);
    sb.delete();
  endtask
`endif

  task automatic test_reset_mid();
    bit popped; logic [7:0] pd; logic [3:0] po;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hA1; in_op = 4'h8; cycle(popped, pd, po);
    in_data = 8'hA2; in_op = 4'h9; cycle(popped, pd, po);
    #1;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL mid_full got=%0d exp=2", count); end
    rst = 1'b1; in_data = 8'hA3;
    cycle(popped, pd, po);
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    checks++; if (count !== 2'd0)     begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL mid_out_data got=%h exp=00", out_data); end
    out_ready = 1'b1;
    cycle(popped, pd, po);
    checks++; if (popped || count !== 2'd0) begin
      failures++; $display("FAIL mid_discard got=count:%0d exp=0", count);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_op = '0;
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_fill_stall();
    test_simultaneous();
    test_wrap();
`ifdef ALU_RESULT_FLAGS_EN
    test_flags();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Two-entry registered result buffer sitting directly downstream of the ALU operation modules (mov, add, logic, etc.). It captures the `size`-bit result `c` plus the opcode that produced it on a valid/ready handshake, optionally derives zero/negative status flags, and presents the results in order to the writeback stage. It decouples ALU combinational output from writeback stalls without losing or duplicating results.

## Interface
- `size`, 8, datapath width in bits; matches the ALU module `size`.
- `opw`, 4, opcode tag width in bits.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ALU result available this cycle.
- `in_ready`  out  1  buffer can accept; high iff fewer than 2 entries are held.
- `in_data`  in  size  ALU result (`c` of the selected ALU module).
- `in_op`  in  opw  opcode tag travelling with the result.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  writeback consumes the head entry.
- `out_data`  out  size  head result.
- `out_op`  out  opw  head opcode tag.
- `out_zero`  out  1  head result == 0. Present only with `ALU_RESULT_FLAGS_EN`.
- `out_neg`  out  1  head result MSB. Present only with `ALU_RESULT_FLAGS_EN`.
- `count`  out  2  entries held: 0, 1 or 2.

## Operation
- Storage: 2 entries of {data, op[, zero, neg]}, with 1-bit write pointer, 1-bit read pointer, and 2-bit `count`.
- Push when `in_valid && in_ready`. Entry is written at `wr_ptr`, then `wr_ptr` toggles.
- Pop when `out_valid && out_ready`. `rd_ptr` toggles.
- `count` next value:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
- `in_ready = (count != 2)`. Derived from registered state only; no combinational path from `out_ready`.
- `out_valid = (count != 0)`. `out_data`, `out_op` and flags come from the entry at `rd_ptr`.
- `in_valid` while `in_ready` is low: the input is ignored, with no state change. The ALU holds the result until accepted.
- Flags are computed at push time from `in_data`:
  - zero = ~|in_data
  - neg = in_data[size-1]
- Flags are stored with the entry, never recomputed at the output.
- Pointer wrap: 1-bit pointers wrap 1→0 naturally.
- Ordering is strict FIFO.
- Data fields are not cleared on pop. Only `out_valid` qualifies them.
- Reset mid-operation discards all held entries, including one being pushed or popped in the same cycle.

## Timing
- Reset values:
  - `count` = 0, `out_valid` = 0, `in_ready` = 1.
  - Pointers = 0.
  - `out_data` = 0, `out_op` = 0, `out_zero` = 1, `out_neg` = 0.
  - Storage is cleared to 0.
- Latency: a result pushed in cycle N appears with `out_valid` high in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 result/cycle sustained while `out_ready` is held high.
- Full (count=2): `in_ready` drops in the cycle after the second push. A pop in that cycle raises `in_ready` in the next cycle.
- Empty with simultaneous push: `count` goes 0→1. `out_valid` stays low in the push cycle.
- `out_ready` while empty: ignored.

## Configuration
- `ALU_RESULT_FLAGS_EN` defined:
  - `out_zero`/`out_neg` ports and per-entry flag storage exist.
  - Flags follow the rules above.
- Not defined:
  - Ports and flag storage are omitted.
  - The entry holds data and op only; all other behaviour is identical.

## Test plan
- Reset then idle: assert `rst` 1 cycle.
  - Outputs must be `count`=0, `out_valid`=0, `in_ready`=1, `out_data`=0x00.
  - With `ALU_RESULT_FLAGS_EN`: `out_zero`=1.
- Single pass-through: push data 0x5A, op 3 with `out_ready`=1.
  - Next cycle: `out_valid`=1, `out_data`=0x5A, `out_op`=3.
  - Cycle after: `out_valid`=0.
- Fill and stall: `out_ready`=0, push 0x11 then 0x22, then keep `in_valid` high with 0x33.
  - `count`=2 and `in_ready`=0; 0x33 is not accepted.
  - Raise `out_ready`: outputs 0x11, 0x22, then 0x33 in order, one per cycle.
- Simultaneous push/pop at count=1: push 0x44 while popping.
  - `count` stays 1; next head is 0x44.
  - Pointers wrap with no loss over 10 consecutive results 0x00..0x09.
- Flags (macro defined): push 0x00, 0x80, 0x7F.
  - (zero, neg) = (1,0), (0,1), (0,0) respectively.
- Reset mid-operation: with `count`=2, assert `rst` while `in_valid`=1.
  - Next cycle: `count`=0, `out_valid`=0; pushed data is discarded.
